spin_pulse_gen: RTL and testbench
=================================

// Module: spin_pulse_gen
//
// PURPOSE
// Turns a stream of 16-bit spin amplitudes into time-multiplexed DAC pulse words.
// It feeds the 256-bit dac_word_in of the DAC sample shifter, one word per clk.
// Each spin occupies one word slot, and each frame of num_spins slots is followed by gap_words zero words.
// The pulse train is continuous until a stop request; stop is honoured at the frame boundary.
//
// PARAMETERS
// SAMPLE_W   16                   bits per DAC sample
// SAMPLES    16                   samples per DAC word; sample 0 is earliest in time
// WORD_W     SAMPLE_W*SAMPLES     derived; must equal 256 (elaboration $error otherwise)
//
// PORTS
// clk           in   1       DAC-domain clock, one DAC word per cycle
// rst           in   1       asynchronous, active-low reset
// start         in   1       1-cycle pulse; begins pulse train (IDLE only)
// stop          in   1       1-cycle pulse; request halt at end of current frame
// num_spins     in   8       spins per frame, 1..255; sampled on start
// gap_words     in   8       zero words after each frame, 0..255; sampled on start
// pulse_width   in   5       samples driven per slot, 1..16; sampled on start
// amp_in        in   16      spin amplitude, two's complement
// amp_valid     in   1       amp_in valid
// amp_ready     out  1       block accepts amp_in this cycle
// dac_word_out  out  256     sample i on bits [16i+15:16i]
// frame_sync    out  1       high with the word of spin 0 of each frame
// busy          out  1       high in any state other than IDLE
// underflow     out  1       sticky; a PULSE slot found amp_valid low
//
// BEHAVIOUR
// - Reset (async, rst=0): state IDLE; dac_word_out=0; frame_sync, busy, underflow, amp_ready=0; counters and pending-stop cleared.
// - States are IDLE, PULSE and GAP; all outputs are registered.
// - IDLE: amp_ready=0 and dac_word_out=0.
//   - start with num_spins!=0: latch cfg, spin_cnt=0, clear underflow, go to PULSE.
//   - start with num_spins==0: ignored, stay IDLE.
// - PULSE: amp_ready=1 combinationally while in PULSE. Each cycle is one slot.
//   - Handshake: transfer = amp_valid & amp_ready.
//   - Output word: samples 0..pw-1 = amp_in, remaining samples = 0.
//   - If pulse_width was latched as 0 or >16, it is treated as 16.
//   - No transfer: the slot emits a zero word, sets underflow, and spin_cnt still advances (timing never slips).
//   - Latency: an amp accepted in cycle n appears on dac_word_out in cycle n+1.
//   - frame_sync is asserted in cycle n+1 for the slot with spin_cnt==0.
//   - On spin_cnt==num_spins-1:
//     - gap_words!=0: go to GAP with gap_cnt=0.
//     - else if stop is pending: go to IDLE.
//     - else: stay in PULSE with spin_cnt=0.
// - GAP: amp_ready=0; dac_word_out=0 for exactly gap_words cycles.
//   - After the last gap cycle: go to IDLE if stop is pending, else PULSE with spin_cnt=0.
// - stop is latched as pending in any non-IDLE state.
//   - It is cleared on entering IDLE.
//   - A stop in the same cycle as the last slot still takes effect at that boundary.
//   - stop in IDLE is ignored; start in a non-IDLE state is ignored.
// - After halt, the next clock drives a zero word, busy=0 and frame_sync=0.
// - underflow stays set until the next accepted start or reset.
// - Reset mid-frame: immediate zero output; any in-flight amp is discarded.
// - Counters are 8 bits; no wrap beyond 255 is possible given the latched limits.
//
// TESTING
// 1 num_spins=4, gap=2, pw=4, amps 1..4 always valid:
//   -> words: 4 pulses of samples0-3=amp, then 2 zero words, repeating.
//   -> frame_sync every 6 cycles; latency 1 cycle.
// 2 pw=16, amp=16'h8000:
//   -> all 16 samples = 8000; pw=0 behaves identically.
// 3 amp_valid low on spin 2 only:
//   -> that slot emits zero; underflow=1 and stays 1; frame length unchanged; a new start clears it.
// 4 stop mid-frame (spin 1 of 4, gap 3):
//   -> frame and gap complete, then IDLE; busy falls 1 cycle after the last gap word.
//   -> gap=0: IDLE directly after spin 3.
// 5 num_spins=0 start -> stays IDLE, busy=0; start while busy -> ignored, config unchanged.
// 6 rst low mid-PULSE:
//   -> dac_word_out=0, all flags 0 asynchronously; normal operation after release and start.

Source files
------------

// File: rtl/spin_pulse_gen.sv
// Spin amplitude -> time-multiplexed 256-bit DAC pulse words.
// Frames of num_spins slots plus gap_words zero words, repeated until a stop is taken at a frame boundary.

module spin_pulse_lane #(
  parameter int SAMPLE_W = 16
) (
  input  logic                en,
  input  logic [SAMPLE_W-1:0] amp,
  output logic [SAMPLE_W-1:0] sample
);
  assign sample = en ? amp : '0;
endmodule

module spin_pulse_gen #(
  parameter int SAMPLE_W = 16,
  parameter int SAMPLES  = 16,
  parameter int WORD_W   = SAMPLE_W*SAMPLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        num_spins,
  input  logic [7:0]        gap_words,
  input  logic [4:0]        pulse_width,
  input  logic [15:0]       amp_in,
  input  logic              amp_valid,
  output logic              amp_ready,
  output logic [WORD_W-1:0] dac_word_out,
  output logic              frame_sync,
  output logic              busy,
  output logic              underflow
);

  if (WORD_W != 256) begin : g_bad_word_w
    $error("spin_pulse_gen: WORD_W must be 256");
  end

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t     state;
  logic [7:0] spin_cnt, gap_cnt, n_spins_q, gap_q;
  logic [4:0] pw_q, pw_eff;
  logic       stop_pend, stop_now, xfer;
  logic [SAMPLES-1:0][SAMPLE_W-1:0] word_d;

  assign amp_ready = (state == PULSE);
  assign xfer      = amp_valid & amp_ready;
  assign stop_now  = stop_pend | stop;
  // Out-of-range widths fall back to a full-word pulse.
  assign pw_eff    = (pw_q == 5'd0 || pw_q > 5'(SAMPLES)) ? 5'(SAMPLES) : pw_q;

  for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
    spin_pulse_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
      .en     (xfer && (5'(i) < pw_eff)),
      .amp    (amp_in),
      .sample (word_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      spin_cnt     <= '0;
      gap_cnt      <= '0;
      n_spins_q    <= '0;
      gap_q        <= '0;
      pw_q         <= '0;
      stop_pend    <= 1'b0;
      dac_word_out <= '0;
      frame_sync   <= 1'b0;
      busy         <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      dac_word_out <= '0;
      frame_sync   <= 1'b0;
      // busy tracks the word stream: it covers every word produced outside IDLE.
      busy         <= (state != IDLE);
      if (state != IDLE && stop) stop_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start && num_spins != 8'd0) begin
            n_spins_q <= num_spins;
            gap_q     <= gap_words;
            pw_q      <= pulse_width;
            spin_cnt  <= '0;
            underflow <= 1'b0;
            state     <= PULSE;
          end
        end
        PULSE: begin
          dac_word_out <= word_d;
          frame_sync   <= (spin_cnt == 8'd0);
          if (!amp_valid) underflow <= 1'b1;
          if (spin_cnt == n_spins_q - 8'd1) begin
            if (gap_q != 8'd0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else if (stop_now) begin
              stop_pend <= 1'b0;
              state     <= IDLE;
            end else begin
              spin_cnt <= '0;
            end
          end else begin
            spin_cnt <= spin_cnt + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt == gap_q - 8'd1) begin
            if (stop_now) begin
              stop_pend <= 1'b0;
              state     <= IDLE;
            end else begin
              spin_cnt <= '0;
              state    <= PULSE;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spin_pulse_gen.sv
// Randomized bench for spin_pulse_gen; expected word stream derived from frame arithmetic
// (slot position = t mod (spins+gap), halt at the end of the frame containing the stop).

module tb_spin_pulse_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, stop = 1'b0;
  logic [7:0]   num_spins = '0, gap_words = '0;
  logic [4:0]   pulse_width = '0;
  logic [15:0]  amp_in = '0;
  logic         amp_valid = 1'b0;
  logic         amp_ready;
  logic [255:0] dac_word_out;
  logic         frame_sync, busy, underflow;

  int checks = 0;
  int errors = 0;

  bit [15:0] amps [0:2047];
  bit        vld  [0:2047];

  spin_pulse_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .num_spins(num_spins), .gap_words(gap_words), .pulse_width(pulse_width),
    .amp_in(amp_in), .amp_valid(amp_valid), .amp_ready(amp_ready),
    .dac_word_out(dac_word_out), .frame_sync(frame_sync), .busy(busy),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input logic [15:0] a, input int pw);
    int e;
    logic [255:0] w;
    e = (pw == 0 || pw > 16) ? 16 : pw;
    w = '0;
    for (int i = 0; i < e; i++) w[16*i +: 16] = a;
    return w;
  endfunction

  // One start..halt run. Stop is pulsed in run cycle s; a stray start with junk config
  // is pulsed at a random busy cycle and must change nothing.
  task automatic run_cfg(input string name, input int n, input int g, input int pw,
                         input int s, input int vpct, input int bad_t);
    int f, tt, st, j, p;
    logic [255:0] ew;
    logic efs, ebusy, euf, erdy;
    bit uf_acc;
    f  = n + g;
    tt = (s / f + 1) * f;
    st = $urandom_range(tt - 1, 0);
    @(negedge clk);
    num_spins = n[7:0]; gap_words = g[7:0]; pulse_width = pw[4:0];
    start = 1'b1; stop = 1'b0; amp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    num_spins = 8'($urandom); gap_words = 8'($urandom); pulse_width = 5'($urandom);
    uf_acc = 1'b0;
    for (int t = 0; t <= tt + 2; t++) begin
      ew = '0; efs = 1'b0; ebusy = 1'b0;
      if (t > 0 && t - 1 < tt) begin
        j = t - 1;
        p = j % f;
        ebusy = 1'b1;
        efs = (p == 0);
        if (p < n) begin
          if (vld[j]) ew = pat(amps[j], pw);
          else uf_acc = 1'b1;
        end
      end
      euf  = uf_acc;
      erdy = (t < tt) && ((t % f) < n);
      checks += 5;
      if (dac_word_out !== ew) begin
        errors++;
        $display("FAIL %s word t=%0d got %h exp %h", name, t, dac_word_out, ew);
      end
      if (frame_sync !== efs) begin
        errors++;
        $display("FAIL %s frame_sync t=%0d got %b exp %b", name, t, frame_sync, efs);
      end
      if (busy !== ebusy) begin
        errors++;
        $display("FAIL %s busy t=%0d got %b exp %b", name, t, busy, ebusy);
      end
      if (underflow !== euf) begin
        errors++;
        $display("FAIL %s underflow t=%0d got %b exp %b", name, t, underflow, euf);
      end
      if (amp_ready !== erdy) begin
        errors++;
        $display("FAIL %s amp_ready t=%0d got %b exp %b", name, t, amp_ready, erdy);
      end
      vld[t]    = (t == bad_t) ? 1'b0 : ($urandom_range(99, 0) < vpct);
      amps[t]   = 16'($urandom);
      amp_valid = vld[t];
      amp_in    = amps[t];
      stop      = (t == s);
      start     = (t == st);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; amp_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks += 5;
    if (dac_word_out !== '0 || frame_sync !== 1'b0 || busy !== 1'b0 ||
        underflow !== 1'b0 || amp_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs got word=%h fs=%b busy=%b uf=%b rdy=%b exp all 0",
               dac_word_out, frame_sync, busy, underflow, amp_ready);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_cfg("basic", 4, 2, 4, 13, 100, -1);
  endtask

  task automatic test_full_width();
    run_cfg("pw16", 3, 1, 16, 5, 100, -1);
    run_cfg("pw0", 3, 1, 0, 5, 100, -1);
    run_cfg("pw_over", 2, 0, 25, 3, 100, -1);
  endtask

  task automatic test_underflow();
    run_cfg("uf_spin2", 4, 2, 4, 9, 100, 2);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky got %b exp 1", underflow);
    end
    run_cfg("uf_clear", 4, 2, 4, 3, 100, -1);
  endtask

  task automatic test_stop();
    run_cfg("stop_gap3", 4, 3, 4, 1, 100, -1);
    run_cfg("stop_gap0", 4, 0, 4, 1, 100, -1);
    run_cfg("stop_last_slot", 4, 0, 7, 3, 100, -1);
    run_cfg("stop_last_gap", 2, 2, 5, 7, 100, -1);
  endtask

  task automatic test_ignored();
    run_cfg("pre_ignored", 2, 1, 8, 0, 100, 0);
    @(negedge clk);
    num_spins = 8'd0; gap_words = 8'd3; pulse_width = 5'd4; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks += 4;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_spins busy k=%0d got %b exp 0", k, busy);
      end
      if (amp_ready !== 1'b0) begin
        errors++;
        $display("FAIL zero_spins amp_ready k=%0d got %b exp 0", k, amp_ready);
      end
      if (dac_word_out !== '0) begin
        errors++;
        $display("FAIL zero_spins word k=%0d got %h exp 0", k, dac_word_out);
      end
      if (underflow !== 1'b1) begin
        errors++;
        $display("FAIL zero_spins underflow k=%0d got %b exp 1", k, underflow);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    num_spins = 8'd4; gap_words = 8'd2; pulse_width = 5'd4; start = 1'b1;
    amp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; amp_valid = 1'b0; amp_in = 16'h1234;
    @(negedge clk);
    amp_valid = 1'b1;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b1 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset busy/uf got %b/%b exp 1/1", busy, underflow);
    end
    if (dac_word_out !== pat(16'h1234, 4)) begin
      errors++;
      $display("FAIL pre_reset word got %h exp %h", dac_word_out, pat(16'h1234, 4));
    end
    #2 rst = 1'b0;
    #1;
    checks += 5;
    if (dac_word_out !== '0) begin
      errors++;
      $display("FAIL mid_reset word got %h exp 0", dac_word_out);
    end
    if (frame_sync !== 1'b0 || busy !== 1'b0 || underflow !== 1'b0 || amp_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset flags got fs=%b busy=%b uf=%b rdy=%b exp 0", frame_sync, busy,
               underflow, amp_ready);
    end
    @(negedge clk);
    rst = 1'b1; amp_valid = 1'b0;
    run_cfg("after_reset", 3, 2, 6, 4, 100, -1);
  endtask

  task automatic test_random();
    int n, g;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(6, 1);
      g = $urandom_range(4, 0);
      run_cfg("random", n, g, $urandom_range(31, 0), $urandom_range(3 * (n + g) - 1, 0), 85, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_width();
    test_underflow();
    test_stop();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
